// File: rtl/inv_test_seq.sv
// Inverter-chain test sequencer: drives an 8-bit pattern one bit at a time and measures
// how many cycles the synchronized response takes to reach the expected level.
module inv_test_seq #(
    parameter int unsigned DLY_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ena,
    input  logic             start,
    input  logic [7:0]       pattern,
    input  logic [3:0]       bit_len,
    input  logic [DLY_W-1:0] timeout,
    input  logic             invert_exp,
    input  logic             resp_in,
    output logic             stim_out,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [3:0]       err_cnt,
    output logic [DLY_W-1:0] last_dly
);

    typedef enum logic [1:0] {StIdle, StWait, StHold, StDone} state_e;

    state_e           st_q, st_d;
    logic             stim_q, stim_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             pass_q, pass_d;
    logic [3:0]       err_q, err_d;
    logic [DLY_W-1:0] last_q, last_d;
    logic [2:0]       idx_q, idx_d;
    logic [DLY_W-1:0] dly_q, dly_d;
    logic [3:0]       hold_q, hold_d;
    logic [7:0]       pat_q, pat_d;
    logic [3:0]       len_q, len_d;
    logic [DLY_W-1:0] tmo_q, tmo_d;
    logic             inv_q, inv_d;
    logic             sync1_q, sync2_q;

    logic             resp_s;
    logic             exp_resp;
    logic [2:0]       idx_nxt;

    assign resp_s = sync2_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st_q    <= StIdle;
            stim_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
            err_q   <= '0;
            last_q  <= '0;
            idx_q   <= '0;
            dly_q   <= '0;
            hold_q  <= '0;
            pat_q   <= '0;
            len_q   <= '0;
            tmo_q   <= '0;
            inv_q   <= 1'b0;
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else if (ena) begin
            st_q    <= st_d;
            stim_q  <= stim_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            pass_q  <= pass_d;
            err_q   <= err_d;
            last_q  <= last_d;
            idx_q   <= idx_d;
            dly_q   <= dly_d;
            hold_q  <= hold_d;
            pat_q   <= pat_d;
            len_q   <= len_d;
            tmo_q   <= tmo_d;
            inv_q   <= inv_d;
            sync1_q <= resp_in;
            sync2_q <= sync1_q;
        end
    end

    always_comb begin
        st_d     = st_q;
        stim_d   = stim_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        pass_d   = pass_q;
        err_d    = err_q;
        last_d   = last_q;
        idx_d    = idx_q;
        dly_d    = dly_q;
        hold_d   = hold_q;
        pat_d    = pat_q;
        len_d    = len_q;
        tmo_d    = tmo_q;
        inv_d    = inv_q;
        exp_resp = inv_q ? ~stim_q : stim_q;
        idx_nxt  = idx_q + 3'd1;

        unique case (st_q)
            StIdle: begin
                if (start) begin
                    pat_d  = pattern;
                    len_d  = bit_len;
                    tmo_d  = timeout;
                    inv_d  = invert_exp;
                    stim_d = pattern[0];
                    idx_d  = '0;
                    dly_d  = '0;
                    err_d  = '0;
                    busy_d = 1'b1;
                    st_d   = StWait;
                end
            end
            StWait: begin
                // A match wins over a timeout landing in the same cycle.
                if (resp_s == exp_resp) begin
                    last_d = dly_q;
                    hold_d = '0;
                    st_d   = StHold;
                end else if (dly_q == tmo_q) begin
                    err_d  = (err_q == 4'd8) ? err_q : err_q + 4'd1;
                    last_d = tmo_q;
                    hold_d = '0;
                    st_d   = StHold;
                end else begin
                    dly_d = dly_q + DLY_W'(1);
                end
            end
            StHold: begin
                if (hold_q == len_q) begin
                    if (idx_q != 3'd7) begin
                        idx_d  = idx_nxt;
                        stim_d = pat_q[idx_nxt];
                        dly_d  = '0;
                        st_d   = StWait;
                    end else begin
                        done_d = 1'b1;
                        st_d   = StDone;
                    end
                end else begin
                    hold_d = hold_q + 4'd1;
                end
            end
            StDone: begin
                pass_d = (err_q == 4'd0);
                busy_d = 1'b0;
                st_d   = StIdle;
            end
            default: st_d = StIdle;
        endcase
    end

    assign stim_out = stim_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign pass     = pass_q;
    assign err_cnt  = err_q;
    assign last_dly = last_q;

endmodule

// File: tb/tb_inv_test_seq.sv
// Bench for inv_test_seq: a behavioural response model (ideal, delayed or stuck) feeds the
// DUT, and each run is checked against a per-bit delay model of the whole sequence.
module tb_inv_test_seq;

    localparam int DLY_W = 8;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             ena;
    logic             start;
    logic [7:0]       pattern;
    logic [3:0]       bit_len;
    logic [DLY_W-1:0] timeout;
    logic             invert_exp;
    logic             resp_in;
    logic             stim_out;
    logic             busy;
    logic             done;
    logic             pass;
    logic [3:0]       err_cnt;
    logic [DLY_W-1:0] last_dly;

    inv_test_seq #(.DLY_W(DLY_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .ena        (ena),
        .start      (start),
        .pattern    (pattern),
        .bit_len    (bit_len),
        .timeout    (timeout),
        .invert_exp (invert_exp),
        .resp_in    (resp_in),
        .stim_out   (stim_out),
        .busy       (busy),
        .done       (done),
        .pass       (pass),
        .err_cnt    (err_cnt),
        .last_dly   (last_dly)
    );

    always #5 clk = ~clk;

    // Response model: inverter chain with resp_dly cycles of delay, or a stuck line.
    bit         stuck;
    bit         stuck_val;
    int         resp_dly;
    logic [7:0] line;

    always @(posedge clk) line <= {line[6:0], ~stim_out};

    always_comb begin
        if (stuck) resp_in = stuck_val;
        else if (resp_dly == 0) resp_in = ~stim_out;
        else resp_in = line[resp_dly-1];
    end

    int n_chk = 0;
    int n_fail = 0;
    bit prev_stim;
    int e_err, e_last, e_max, e_cyc, e_first;
    int o_done_cyc, o_ndone, o_err, o_last, o_max, o_pass, o_busy, o_stim;

    // Per bit: cycles until the synchronized response is right (or never), then timeout rule.
    function automatic void model(input logic [7:0] pat, input int blen, input int tmo,
                                  input bit inv, input bit prev);
        bit p;
        bit s;
        int need;
        int last;
        p = prev;
        e_err = 0;
        e_max = 0;
        e_cyc = 1;
        e_first = 0;
        last = 0;
        for (int i = 0; i < 8; i++) begin
            s = pat[i];
            if (stuck) need = (stuck_val == (inv ? !s : s)) ? 0 : -1;
            else if (inv) need = (s != p) ? resp_dly + 2 : 0;
            else need = (s != p) ? 0 : -1;
            if (need >= 0 && need <= tmo) last = need;
            else begin
                e_err++;
                last = tmo;
            end
            if (i == 0) e_first = last + 2;
            if (last > e_max) e_max = last;
            e_cyc += last + blen + 2;
            p = s;
        end
        e_last = last;
    endfunction

    task automatic do_run(input logic [7:0] pat, input int blen, input int tmo, input bit inv,
                          input bit pulse, input int drop);
        model(pat, blen, tmo, inv, prev_stim);
        if (drop > 0) begin
            e_cyc += 4;
            if (drop < e_first) e_first += 4;
        end
        @(negedge clk);
        pattern = pat;
        bit_len = 4'(blen);
        timeout = 8'(tmo);
        invert_exp = inv;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        o_done_cyc = 0;
        o_ndone = 0;
        o_max = 0;
        for (int c = 1; c <= 800; c++) begin
            if (c > 1) @(negedge clk);
            if (done) begin
                o_ndone++;
                if (o_done_cyc == 0) o_done_cyc = c;
            end
            if (c >= e_first && o_done_cyc == 0 && int'(last_dly) > o_max) o_max = int'(last_dly);
            if (o_done_cyc != 0 && c >= o_done_cyc + 3) break;
            // Inputs wander during the run; the DUT must use its start-time copies.
            pattern = 8'($urandom);
            bit_len = 4'($urandom);
            timeout = 8'($urandom);
            invert_exp = 1'($urandom);
            start = pulse && (c == 3);
            if (drop > 0 && c == drop) ena = 1'b0;
            if (drop > 0 && c == drop + 4) ena = 1'b1;
        end
        start = 1'b0;
        ena = 1'b1;
        o_err = int'(err_cnt);
        o_last = int'(last_dly);
        o_pass = int'(pass);
        o_busy = int'(busy);
        o_stim = int'(stim_out);
        prev_stim = pat[7];
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        n_chk++; if (stim_out !== 1'b0) begin n_fail++; $display("FAIL rst_stim: got %0b expected 0", stim_out); end
        n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %0b expected 0", busy); end
        n_chk++; if (done !== 1'b0) begin n_fail++; $display("FAIL rst_done: got %0b expected 0", done); end
        n_chk++; if (pass !== 1'b0) begin n_fail++; $display("FAIL rst_pass: got %0b expected 0", pass); end
        n_chk++; if (err_cnt !== 4'd0) begin n_fail++; $display("FAIL rst_err: got %0d expected 0", err_cnt); end
        n_chk++; if (last_dly !== 8'd0) begin n_fail++; $display("FAIL rst_last: got %0d expected 0", last_dly); end
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL idle_busy: got %0b expected 0", busy); end
        prev_stim = 1'b0;
    endtask

    task automatic test_ideal;
        stuck = 1'b0;
        resp_dly = 0;
        do_run(8'h00, 0, 5, 1'b1, 1'b0, 0);
        n_chk++; if (o_done_cyc !== 17) begin n_fail++; $display("FAIL z_done_cyc: got %0d expected 17", o_done_cyc); end
        n_chk++; if (o_pass !== 1) begin n_fail++; $display("FAIL z_pass: got %0d expected 1", o_pass); end
        n_chk++; if (o_err !== 0) begin n_fail++; $display("FAIL z_err: got %0d expected 0", o_err); end
        n_chk++; if (o_last !== 0) begin n_fail++; $display("FAIL z_last: got %0d expected 0", o_last); end
        do_run(8'hA5, 3, 20, 1'b1, 1'b0, 0);
        n_chk++; if (o_last !== 2) begin n_fail++; $display("FAIL a5_last: got %0d expected 2", o_last); end
        n_chk++; if (o_err !== 0) begin n_fail++; $display("FAIL a5_err: got %0d expected 0", o_err); end
        n_chk++; if (o_pass !== 1) begin n_fail++; $display("FAIL a5_pass: got %0d expected 1", o_pass); end
        n_chk++; if (o_done_cyc !== e_cyc) begin n_fail++; $display("FAIL a5_cyc: got %0d expected %0d", o_done_cyc, e_cyc); end
        n_chk++; if (o_stim !== 1) begin n_fail++; $display("FAIL a5_stim_hold: got %0d expected 1", o_stim); end
    endtask

    task automatic test_reset_midrun;
        int nd;
        stuck = 1'b1;
        stuck_val = 1'b0;
        repeat (4) @(negedge clk);
        pattern = 8'hFF;
        bit_len = 4'd0;
        timeout = 8'd1;
        invert_exp = 1'b0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (7) @(negedge clk);
        n_chk++; if (busy !== 1'b1) begin n_fail++; $display("FAIL mid_busy_pre: got %0b expected 1", busy); end
        n_chk++; if (err_cnt !== 4'd2) begin n_fail++; $display("FAIL mid_err_pre: got %0d expected 2", err_cnt); end
        rst_n = 1'b0;
        #1;
        n_chk++; if (stim_out !== 1'b0) begin n_fail++; $display("FAIL mid_stim: got %0b expected 0", stim_out); end
        n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL mid_busy: got %0b expected 0", busy); end
        n_chk++; if (pass !== 1'b0) begin n_fail++; $display("FAIL mid_pass: got %0b expected 0", pass); end
        n_chk++; if (err_cnt !== 4'd0) begin n_fail++; $display("FAIL mid_err: got %0d expected 0", err_cnt); end
        n_chk++; if (last_dly !== 8'd0) begin n_fail++; $display("FAIL mid_last: got %0d expected 0", last_dly); end
        @(negedge clk);
        rst_n = 1'b1;
        nd = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (done || busy) nd++;
        end
        n_chk++; if (nd !== 0) begin n_fail++; $display("FAIL mid_no_done: got %0d active cycles expected 0", nd); end
        prev_stim = 1'b0;
    endtask

    task automatic test_stuck;
        stuck = 1'b1;
        stuck_val = 1'b0;
        repeat (6) @(negedge clk);
        do_run(8'hFF, 2, 10, 1'b0, 1'b0, 0);
        n_chk++; if (o_err !== 8) begin n_fail++; $display("FAIL stuck_err: got %0d expected 8", o_err); end
        n_chk++; if (o_pass !== 0) begin n_fail++; $display("FAIL stuck_pass: got %0d expected 0", o_pass); end
        n_chk++; if (o_last !== 10) begin n_fail++; $display("FAIL stuck_last: got %0d expected 10", o_last); end
        n_chk++; if (o_done_cyc !== e_cyc) begin n_fail++; $display("FAIL stuck_cyc: got %0d expected %0d", o_done_cyc, e_cyc); end
    endtask

    task automatic test_delay;
        stuck = 1'b0;
        resp_dly = 5;
        repeat (12) @(negedge clk);
        do_run(8'h01, 2, 20, 1'b1, 1'b0, 0);
        n_chk++; if (o_max !== 7) begin n_fail++; $display("FAIL dly_transition: got %0d expected 7", o_max); end
        n_chk++; if (o_pass !== 1) begin n_fail++; $display("FAIL dly_pass: got %0d expected 1", o_pass); end
        n_chk++; if (o_last !== e_last) begin n_fail++; $display("FAIL dly_last: got %0d expected %0d", o_last, e_last); end
        n_chk++; if (o_done_cyc !== e_cyc) begin n_fail++; $display("FAIL dly_cyc: got %0d expected %0d", o_done_cyc, e_cyc); end
    endtask

    task automatic test_control;
        stuck = 1'b0;
        resp_dly = 0;
        repeat (10) @(negedge clk);
        do_run(8'h3C, 1, 9, 1'b1, 1'b1, 0);
        n_chk++; if (o_ndone !== 1) begin n_fail++; $display("FAIL busy_start_pulses: got %0d expected 1", o_ndone); end
        n_chk++; if (o_done_cyc !== e_cyc) begin n_fail++; $display("FAIL busy_start_cyc: got %0d expected %0d", o_done_cyc, e_cyc); end
        n_chk++; if (o_busy !== 0) begin n_fail++; $display("FAIL busy_start_idle: got %0d expected 0", o_busy); end
        do_run(8'h5A, 2, 9, 1'b1, 1'b0, 2);
        n_chk++; if (o_done_cyc !== e_cyc) begin n_fail++; $display("FAIL ena_cyc: got %0d expected %0d", o_done_cyc, e_cyc); end
        n_chk++; if (o_last !== e_last) begin n_fail++; $display("FAIL ena_last: got %0d expected %0d", o_last, e_last); end
        n_chk++; if (o_err !== e_err) begin n_fail++; $display("FAIL ena_err: got %0d expected %0d", o_err, e_err); end
        n_chk++; if (o_ndone !== 1) begin n_fail++; $display("FAIL ena_pulses: got %0d expected 1", o_ndone); end
    endtask

    task automatic test_random;
        logic [7:0] pat;
        int blen, tmo;
        bit inv;
        for (int r = 0; r < 16; r++) begin
            stuck = 1'($urandom_range(3, 0) == 0);
            stuck_val = 1'($urandom);
            resp_dly = $urandom_range(3, 0);
            pat = 8'($urandom);
            inv = 1'($urandom);
            // bit_len >= delay keeps every response settled before the next bit starts.
            blen = stuck ? $urandom_range(15, 0) : $urandom_range(15, resp_dly);
            tmo = $urandom_range(20, 0);
            repeat (8) @(negedge clk);
            do_run(pat, blen, tmo, inv, 1'b0, 0);
            n_chk++; if (o_err !== e_err) begin n_fail++; $display("FAIL rnd%0d_err: got %0d expected %0d", r, o_err, e_err); end
            n_chk++; if (o_last !== e_last) begin n_fail++; $display("FAIL rnd%0d_last: got %0d expected %0d", r, o_last, e_last); end
            n_chk++; if (o_done_cyc !== e_cyc) begin n_fail++; $display("FAIL rnd%0d_cyc: got %0d expected %0d", r, o_done_cyc, e_cyc); end
            n_chk++; if (o_pass !== int'(e_err == 0)) begin n_fail++; $display("FAIL rnd%0d_pass: got %0d expected %0d", r, o_pass, int'(e_err == 0)); end
            n_chk++; if (o_stim !== int'(pat[7])) begin n_fail++; $display("FAIL rnd%0d_stim: got %0d expected %0d", r, o_stim, pat[7]); end
        end
    endtask

    initial begin
        rst_n = 1'b0;
        ena = 1'b1;
        start = 1'b0;
        pattern = '0;
        bit_len = '0;
        timeout = '0;
        invert_exp = 1'b0;
        stuck = 1'b0;
        stuck_val = 1'b0;
        resp_dly = 0;
        prev_stim = 1'b0;
        test_reset();
        test_ideal();
        test_reset_midrun();
        test_stuck();
        test_delay();
        test_control();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
